letter_encoder_pipe: RTL
========================

# letter_encoder_pipe

Parametrised, handshaked one-hot to binary letter encoder for the rotor datapath. It accepts a WIDTH-bit one-hot letter vector on a valid/ready input and returns its index on a registered valid/ready output, with one cycle of latency. A two-entry skid buffer gives full throughput under backpressure. Invalid vectors are flagged per item and counted in a saturating error counter. It sits between the plugboard/rotor one-hot wiring stages and the binary letter consumers.

## Interface
- WIDTH, 26, number of one-hot input lines (letters); legal range 2..64
- LW, $clog2(WIDTH), output index width (derived; 5 at default)
- CNT_W, 8, error counter width
- CLK  in  1  rising-edge clock
- RST_N  in  1  reset, asynchronous, active-low
- DEC  in  WIDTH  one-hot letter vector
- IN_VLD  in  1  DEC valid
- IN_RDY  out  1  block can accept DEC this cycle
- LET  out  LW  encoded letter index
- ERR  out  1  item was invalid (qualified by OUT_VLD)
- OUT_VLD  out  1  LET/ERR valid
- OUT_RDY  in  1  downstream accepts LET/ERR
- CLR_CNT  in  1  synchronous clear of ERR_CNT
- ERR_CNT  out  CNT_W  saturating count of accepted invalid items

## Operation
- Encode (combinational): exactly one bit k set -> LET=k, ERR=0. Zero bits set -> LET=0, ERR=1. Multi-hot -> see Configuration.
- Accept: IN_VLD && IN_RDY. Encoded {LET,ERR} is pushed into a 2-entry FIFO (main stage drives outputs, skid stage behind it).
- Pop: OUT_VLD && OUT_RDY removes the main entry; skid entry (if any) moves to main the same edge.
- Order strictly preserved; no item dropped or duplicated.
- IN_RDY = !skid_full (registered state, no combinational path from OUT_RDY).
- Accept while main empty -> item goes to main. Accept while main full and popped same cycle, skid empty -> item goes to main. Accept while main full, not popped -> item goes to skid.
- ERR_CNT: +1 on each accept whose ERR=1; holds at 2^CNT_W-1. CLR_CNT=1 -> ERR_CNT=0 next edge; clear wins over simultaneous increment.
- Outputs LET/ERR hold stable while OUT_VLD=1 && OUT_RDY=0.

## Timing
- Reset (RST_N low, any time, asynchronous): OUT_VLD=0, LET=0, ERR=0, ERR_CNT=0, IN_RDY=1 (FIFO emptied); in-flight items discarded.
- Latency: item accepted at edge n -> OUT_VLD=1 with its LET after edge n (visible in cycle n+1) when FIFO was empty.
- Throughput: 1 item/cycle while OUT_RDY=1.
- Backpressure: after OUT_RDY falls, block accepts at most one more item (into skid), then IN_RDY=0 next cycle.
- Release: OUT_RDY rising with skid full -> IN_RDY=1 the following cycle.
- ERR_CNT updates on the accept edge, independent of output-side pop.

## Configuration
- LETENC_PRIORITY_EN defined: multi-hot resolves to lowest set bit index, ERR=0; only all-zero flags ERR.
- LETENC_PRIORITY_EN undefined (default): multi-hot -> LET=0, ERR=1, counted in ERR_CNT.

## Test plan
- Reset then sweep DEC=1<<k, k=0..25, OUT_RDY=1 -> LET=k one cycle after each accept, ERR=0, ERR_CNT=0, one output per cycle.
- DEC=26'h0 then DEC=26'h0000005 (default build) -> both LET=0, ERR=1, ERR_CNT=2; with LETENC_PRIORITY_EN: second gives LET=0, ERR=0, ERR_CNT=1.
- Stream k=3,4,5 with OUT_RDY=0 from start -> 3 and 4 accepted, IN_RDY=0 next cycle; OUT_RDY=1 -> outputs 3,4,5 in order, no loss.
- 300 consecutive DEC=0 with CNT_W=8 -> ERR_CNT saturates at 255; CLR_CNT pulsed same cycle as an invalid accept -> ERR_CNT=0.
- RST_N asserted mid-stream with skid full -> OUT_VLD=0, IN_RDY=1 immediately (async), no stale output after release.
- WIDTH=8 build, DEC=8'h80 -> LET=3'd7, ERR=0.

Source files
------------

// File: rtl/letter_encoder_pipe.sv
// ---------------------------------------------------------------------------
// letter_encoder_pipe
//
// Purpose:
//   Converts a one-hot letter vector from the plugboard/rotor wiring stages
//   into a binary letter index for downstream consumers. Input and output use
//   valid/ready handshakes. There is one cycle of latency through a two-entry
//   FIFO. The main entry drives the outputs, and a skid entry sits behind it,
//   so the block sustains one item per cycle under backpressure. IN_RDY is
//   derived only from registered state. Each item that is not a legal one-hot
//   vector is flagged with ERR and counted in a saturating counter.
//
// Build option:
//   LETENC_PRIORITY_EN  when defined, a multi-hot vector resolves to its lowest
//                       set bit with ERR=0, and only all-zero is an error.
//                       When undefined (default), multi-hot gives LET=0, ERR=1.
//
// Parameters:
//   WIDTH  number of one-hot input lines, 2..64 (default 26)
//   CNT_W  error counter width (default 8)
//   LW     output index width, $clog2(WIDTH)
//
// Ports:
//   clk_i        rising-edge clock
//   rst_n_i      asynchronous active-low reset
//   dec_i        one-hot letter vector
//   in_vld_i     dec_i valid
//   in_rdy_o     block can accept dec_i this cycle
//   let_o        encoded letter index
//   err_o        item was invalid (qualified by out_vld_o)
//   out_vld_o    let_o / err_o valid
//   out_rdy_i    downstream accepts let_o / err_o
//   clr_cnt_i    synchronous clear of err_cnt_o (wins over increment)
//   err_cnt_o    saturating count of accepted invalid items
// ---------------------------------------------------------------------------
module letter_encoder_pipe #(
    parameter int WIDTH = 26,
    parameter int CNT_W = 8,
    parameter int LW    = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] dec_i,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    output logic [LW-1:0]    let_o,
    output logic             err_o,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam logic [WIDTH-1:0] DEC_ONE = WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ---------------------------------------------------------------------
    // Combinational encoder
    // ---------------------------------------------------------------------
    logic [LW-1:0] low_idx;
    logic          any_set;
    logic          multi_hot;
    logic [LW-1:0] enc_let;
    logic          enc_err;

    // Index of the lowest set bit. For a legal one-hot vector this is the
    // letter itself.
    always_comb begin
        low_idx = '0;
        any_set = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (dec_i[i] && !any_set) begin
                low_idx = LW'(i);
                any_set = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more bits
    // were set.
    assign multi_hot = |(dec_i & (dec_i - DEC_ONE));

`ifdef LETENC_PRIORITY_EN
    always_comb begin
        enc_err = !any_set;
        enc_let = low_idx;
    end
`else
    always_comb begin
        enc_err = !any_set || multi_hot;
        enc_let = enc_err ? '0 : low_idx;
    end
`endif

    // ---------------------------------------------------------------------
    // Two-entry FIFO: main (drives outputs) + skid
    // ---------------------------------------------------------------------
    logic          main_vld_q, main_vld_d;
    logic [LW-1:0] main_let_q, main_let_d;
    logic          main_err_q, main_err_d;
    logic          skid_vld_q, skid_vld_d;
    logic [LW-1:0] skid_let_q, skid_let_d;
    logic          skid_err_q, skid_err_d;

    logic accept;
    logic pop;

    assign in_rdy_o = !skid_vld_q;
    assign accept   = in_vld_i && in_rdy_o;
    assign pop      = main_vld_q && out_rdy_i;

    always_comb begin
        main_vld_d = main_vld_q;
        main_let_d = main_let_q;
        main_err_d = main_err_q;
        skid_vld_d = skid_vld_q;
        skid_let_d = skid_let_q;
        skid_err_d = skid_err_q;

        if (pop) begin
            if (skid_vld_q) begin
                // The skid entry moves forward. No accept is possible here
                // because in_rdy_o is low while the skid entry is full.
                main_let_d = skid_let_q;
                main_err_d = skid_err_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_let_d = enc_let;
                main_err_d = enc_err;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld_q) begin
                main_vld_d = 1'b1;
                main_let_d = enc_let;
                main_err_d = enc_err;
            end else begin
                skid_vld_d = 1'b1;
                skid_let_d = enc_let;
                skid_err_d = enc_err;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_vld_q <= 1'b0;
            main_let_q <= '0;
            main_err_q <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_let_q <= '0;
            skid_err_q <= 1'b0;
        end else begin
            main_vld_q <= main_vld_d;
            main_let_q <= main_let_d;
            main_err_q <= main_err_d;
            skid_vld_q <= skid_vld_d;
            skid_let_q <= skid_let_d;
            skid_err_q <= skid_err_d;
        end
    end

    assign out_vld_o = main_vld_q;
    assign let_o     = main_let_q;
    assign err_o     = main_err_q;

    // ---------------------------------------------------------------------
    // Saturating error counter. It counts on the accept edge, whatever the
    // output side is doing.
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_cnt_i) begin
            err_cnt_d = '0;
        end else if (accept && enc_err && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;

endmodule
